// File: rtl/regfile_sequencer.sv
// regfile_sequencer: request-driven master for the register file.
// Turns one-word requests (NOP/LDI/MOV/CLR/INC/DEC/SWP/RD) into cycle-accurate
// RegSel/ScrSel/FunSel/OutASel sequences and samples OutA for RD.
// Ports:
//   Clock, Reset            - clock, synchronous active-high reset
//   ReqValid/ReqReady       - request handshake (accept when both high)
//   ReqOp/ReqDst/ReqSrc     - operation, destination and source register index
//   ReqData                 - immediate for LDI
//   RF_OutA                 - register file OutA bus
//   RF_I .. RF_ScrSel       - register file control word (combinational from state)
//   RespData                - value captured by the last RD
//   Done                    - registered one-cycle completion pulse
//   Busy                    - state is not IDLE
module regfile_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [2:0]  ReqOp,
    input  logic [1:0]  ReqDst,
    input  logic [1:0]  ReqSrc,
    input  logic [15:0] ReqData,
    input  logic [15:0] RF_OutA,
    output logic [15:0] RF_I,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [15:0] RespData,
    output logic        Done,
    output logic        Busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_CLR = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_SWP = 3'b110;
    localparam logic [2:0] OP_RD  = 3'b111;

    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    localparam logic [2:0] SEL_S1   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_SW1  = 3'd2,
        ST_SW2  = 3'd3,
        ST_SW3  = 3'd4
    } state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [IW-1:0] dst_q;
    logic [IW-1:0] src_q;
    logic [DW-1:0] data_q;

    // Active-low one-hot enable: index k clears bit (3-k).
    function automatic logic [3:0] enable_of(input logic [IW-1:0] idx);
        logic [3:0] m;
        m = 4'b1111;
        m[IW'(2'd3 - idx)] = 1'b0;
        return m;
    endfunction

    // State, latched request, Done and RespData.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_NOP;
            dst_q    <= '0;
            src_q    <= '0;
            data_q   <= '0;
            Done     <= 1'b0;
            RespData <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ReqValid) begin
                        op_q   <= ReqOp;
                        dst_q  <= ReqDst;
                        src_q  <= ReqSrc;
                        data_q <= ReqData;
                        state  <= (ReqOp == OP_SWP) ? ST_SW1 : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_RD) RespData <= RF_OutA;
                    Done  <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_SW1: state <= ST_SW2;
                ST_SW2: state <= ST_SW3;
                ST_SW3: begin
                    Done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ReqReady   = (state == ST_IDLE) && !Reset;
    assign Busy       = (state != ST_IDLE);
    assign RF_OutBSel = {1'b0, dst_q};

    // Control word decode; the idle word is forced while Reset is high.
    always_comb begin
        RF_RegSel  = 4'b1111;
        RF_ScrSel  = 4'b1111;
        RF_FunSel  = FUN_LOAD;
        RF_OutASel = 3'b000;
        RF_I       = '0;
        if (!Reset) begin
            case (state)
                ST_EXEC: begin
                    case (op_q)
                        OP_LDI: begin
                            RF_I      = data_q;
                            RF_RegSel = enable_of(dst_q);
                        end
                        OP_MOV: begin
                            RF_OutASel = {1'b0, src_q};
                            RF_I       = RF_OutA;
                            RF_RegSel  = enable_of(dst_q);
                        end
                        OP_CLR: begin
                            RF_FunSel = FUN_CLR;
                            RF_RegSel = enable_of(dst_q);
                        end
                        OP_INC: begin
                            RF_FunSel = FUN_INC;
                            RF_RegSel = enable_of(dst_q);
                        end
                        OP_DEC: begin
                            RF_FunSel = FUN_DEC;
                            RF_RegSel = enable_of(dst_q);
                        end
                        OP_RD: RF_OutASel = {1'b0, src_q};
                        default: ;
                    endcase
                end
                ST_SW1: begin
                    RF_OutASel = {1'b0, src_q};
                    RF_I       = RF_OutA;
                    RF_ScrSel  = 4'b0111;
                end
                ST_SW2: begin
                    RF_OutASel = {1'b0, dst_q};
                    RF_I       = RF_OutA;
                    RF_RegSel  = enable_of(src_q);
                end
                ST_SW3: begin
                    RF_OutASel = SEL_S1;
                    RF_I       = RF_OutA;
                    RF_RegSel  = enable_of(dst_q);
                end
                default: ;
            endcase
        end
    end

endmodule
